// File: rtl/fusion_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fusion_ctrl : frame sequencer with valid/last/stall tracking for fusion pipe
// rev 1.0
// ----------------------------------------------------------------------------
module fusion_ctrl #(
   parameter int PIXELS_PER_BEAT = 16,
   parameter int IMAGE_DIM       = 512,
   parameter int PIPE_LATENCY    = 23,
   parameter int BEATS           = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        start,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        stall,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        busy,
   output logic        done,
   output logic [15:0] frame_count
);

   localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [CNT_W-1:0]        beat_cnt;
   logic [PIPE_LATENCY-1:0] valid_sr;
   logic [PIPE_LATENCY-1:0] last_sr;
   logic [15:0]             frame_cnt;

   logic advance;
   logic in_fire;
   logic in_last;
   logic out_fire;
   logic frame_end;

   assign m_valid     = valid_sr[PIPE_LATENCY-1];
   assign m_last      = last_sr[PIPE_LATENCY-1] & m_valid;
   assign stall       = m_valid & ~m_ready;
   assign advance     = ~stall;
   assign s_ready     = (state == RUN) & advance;
   assign in_fire     = s_valid & s_ready;
   assign in_last     = (beat_cnt == LAST_BEAT);
   assign out_fire    = m_valid & m_ready;
   assign frame_end   = (state == DRAIN) & out_fire & m_last;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign frame_count = frame_cnt;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start)              state_nx = RUN;
         RUN:     if (in_fire && in_last) state_nx = DRAIN;
         DRAIN:   if (frame_end)          state_nx = DONE;
         DONE:                            state_nx = IDLE;
         default:                         state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else if (advance) begin
         state <= state_nx;
      end
   end

   // in_fire already implies an advancing edge, so the counter holds on stall
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         beat_cnt <= '0;
      end else if (in_fire) begin
         beat_cnt <= in_last ? '0 : beat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         frame_cnt <= '0;
      end else if (frame_end) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   generate
      if (PIPE_LATENCY > 1) begin : g_sr_multi
         always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
               valid_sr <= '0;
               last_sr  <= '0;
            end else if (advance) begin
               valid_sr <= {valid_sr[PIPE_LATENCY-2:0], in_fire};
               last_sr  <= {last_sr[PIPE_LATENCY-2:0], in_fire & in_last};
            end
         end
      end else begin : g_sr_single
         always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
               valid_sr <= '0;
               last_sr  <= '0;
            end else if (advance) begin
               valid_sr <= in_fire;
               last_sr  <= in_fire & in_last;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fusion_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fusion_ctrl : scoreboard bench for fusion_ctrl (BEATS=4, latency 23)
// rev 1.0
// ----------------------------------------------------------------------------
module tb_fusion_ctrl;

   localparam int PL    = 23;
   localparam int BEATS = 4;

   logic        clk = 1'b0;
   logic        areset;
   logic        start;
   logic        s_valid;
   logic        s_ready;
   logic        stall;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [15:0] frame_count;

   fusion_ctrl #(
      .PIXELS_PER_BEAT (16),
      .IMAGE_DIM       (8),
      .PIPE_LATENCY    (PL)
   ) dut (
      .clk         (clk),
      .areset      (areset),
      .start       (start),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .stall       (stall),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic last;
      int   k;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          adv = 0;
   int          in_beat = 0;
   int          out_count = 0;
   logic [15:0] exp_fc = 16'd0;
   bit          exp_done = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // cycle and advancing-edge counters, sampled with pre-edge values
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!stall) adv <= adv + 1;
   end

   // input side: record each accepted beat with its accepting-edge index
   always begin
      @(negedge clk);
      #2;
      if (areset) begin
         q.delete();
         in_beat = 0;
      end else if (s_valid && s_ready) begin
         q.push_back('{last: (in_beat == BEATS - 1), k: adv + 1});
         in_beat = (in_beat == BEATS - 1) ? 0 : in_beat + 1;
      end
   end

   // output side: pop on every output handshake and compare
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (areset) begin
         exp_done = 1'b0;
      end else begin
         chk("stall_formula", stall, m_valid & ~m_ready);
         if (exp_done) begin
            chk("done_pulse", done, 1);
            chk("frame_count_at_done", frame_count, exp_fc);
            exp_done = 1'b0;
         end else if (done) begin
            chk("unexpected_done", done, 0);
         end
         if (m_valid && q.size() == 0) begin
            chk("spurious_m_valid", m_valid, 0);
         end else if (m_valid && m_ready) begin
            e = q.pop_front();
            chk("m_last", m_last, e.last);
            chk("latency_edges", adv, e.k + PL - 1);
            out_count++;
            if (e.last) begin
               exp_fc   = exp_fc + 16'd1;
               exp_done = 1'b1;
            end
         end
      end
   end

   // one frame; lat = edges from the start edge to the cycle where done is seen
   task automatic run_frame(input bit tog, input bit stl, input bit poke, output int lat);
      int n;
      int st_edge;
      int held;
      int stall_seen;
      bit stl_used;
      bit seen;
      n = 0; held = 0; stall_seen = 0; stl_used = 0; seen = 0; lat = -1;
      out_count = 0;
      @(negedge clk);
      start   = 1'b1;
      s_valid = 1'b1;
      m_ready = 1'b1;
      st_edge = cyc + 1;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         start   = poke && (n == 2 || n == 15);
         s_valid = tog ? n[0] : 1'b1;
         if (stl && !stl_used && out_count == 1 && m_valid) begin
            held     = 5;
            stl_used = 1'b1;
         end
         m_ready = (held == 0);
         #1;
         if (held > 0) begin
            if (stall) stall_seen++;
            held--;
         end
         if (done) begin
            seen = 1'b1;
            lat  = cyc - st_edge;
         end
      end
      // a start arriving in DONE must be ignored
      start = poke && seen;
      @(negedge clk);
      start   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      if (stl) chk("stall_cycles", stall_seen, 5);
   endtask

   initial begin
      int lat;
      int mv_cnt;
      areset  = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_frame_count", frame_count, 0);
      @(negedge clk);
      areset = 1'b0;
      repeat (2) @(negedge clk);

      run_frame(1'b0, 1'b0, 1'b0, lat);
      chk("lat_basic", lat, 27);
      #1 chk("fc_after_first", frame_count, 1);

      run_frame(1'b0, 1'b1, 1'b0, lat);
      chk("lat_stalled", lat, 32);

      run_frame(1'b1, 1'b0, 1'b0, lat);
      chk("lat_bubbles", lat, 30);

      run_frame(1'b0, 1'b0, 1'b1, lat);
      chk("lat_start_pokes", lat, 27);
      repeat (3) @(negedge clk);
      #1 chk("idle_after_poke", busy, 0);
      chk("fc_after_four", frame_count, 4);

      // reset while two beats are in flight and the FSM is still in RUN
      @(negedge clk);
      start   = 1'b1;
      s_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (8) @(negedge clk);
      #3 areset = 1'b1;
      exp_fc = 16'd0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_frame_count", frame_count, 0);
      repeat (2) @(negedge clk);
      areset = 1'b0;
      mv_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (m_valid) mv_cnt++;
      end
      chk("stale_m_valid", mv_cnt, 0);
      chk("no_restart_after_rst", busy, 0);

      // frame counter wrap from preloaded 0xFFFF
      @(negedge clk);
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      exp_fc = 16'hFFFF;
      #1 chk("fc_preload", frame_count, 16'hFFFF);
      run_frame(1'b0, 1'b0, 1'b0, lat);
      chk("lat_wrap", lat, 27);
      #1 chk("fc_wrapped", frame_count, 0);

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
